au_prefix_and_seq: RTL and testbench

AU_PREFIX_AND_SEQ -- requirements
Module: AU_prefix_and_seq

---
 rtl/au_prefix_and_seq.sv | 200 ++++++++++++++++++++
 tb/tb_au_prefix_and_seq.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/au_prefix_and_seq.sv
// -----------------------------------------------------------------------------
// au_prefix_and_seq
//   Chunk-serial prefix-AND scanner. It accepts one WIDTH-bit word and works
//   through it CHUNK bits per cycle using one shared combinational prefix-AND
//   unit. A running carry links each chunk to the one before it. Processing
//   stops early once the carry drops to 0, because every higher result bit is
//   then 0 anyway. The result is held until the consumer takes it.
//
//   Ports
//     clk        in   1      clock, rising edge
//     rst        in   1      synchronous active-high reset
//     in_valid   in   1      input word offered
//     in_ready   out  1      block can accept a word (IDLE and not in reset)
//     in_data    in   WIDTH  word to scan, sampled only at acceptance
//     out_valid  out  1      result available (DONE)
//     out_ready  in   1      consumer accepts the result
//     out_data   out  WIDTH  registered result, bit i = AND of in_data[0..i]
//     busy       out  1      high in RUN or DONE
//
//   au_prefix_and (helper): combinational prefix-AND, po[i] = &d[i:0].
//     ARCH 0 = serial ripple, 1 = Brent-Kung, 2 = Sklansky.
// -----------------------------------------------------------------------------

module au_prefix_and #(
  parameter int WIDTH = 8,
  parameter int ARCH  = 2
) (
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] po
);
  localparam int LVL = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  if (ARCH == 0) begin : g_serial
    always_comb begin
      logic acc;
      acc = 1'b1;
      po  = '0;
      for (int i = 0; i < WIDTH; i++) begin
        acc   = acc & d[i];
        po[i] = acc;
      end
    end
  end else if (ARCH == 1) begin : g_bk
    // Up-sweep builds AND-reductions of aligned power-of-two blocks. The
    // down-sweep then fills the remaining positions from finished prefixes.
    for (genvar l = 0; l < LVL; l++) begin : g_up
      logic [WIDTH-1:0] prev, s;
      if (l == 0) begin : g_first
        assign prev = d;
      end else begin : g_next
        assign prev = g_up[l-1].s;
      end
      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        if (((i + 1) % (2 ** (l + 1))) == 0) begin : g_op
          assign s[i] = prev[i] & prev[i - 2 ** l];
        end else begin : g_pass
          assign s[i] = prev[i];
        end
      end
    end
    for (genvar k = 0; k < LVL; k++) begin : g_dn
      localparam int L = LVL - 1 - k;
      logic [WIDTH-1:0] prev, s;
      if (k == 0) begin : g_first
        assign prev = g_up[LVL-1].s;
      end else begin : g_next
        assign prev = g_dn[k-1].s;
      end
      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        if ((((i + 1) % (2 ** (L + 1))) == 2 ** L) && (i >= 2 ** (L + 1))) begin : g_op
          assign s[i] = prev[i] & prev[i - 2 ** L];
        end else begin : g_pass
          assign s[i] = prev[i];
        end
      end
    end
    assign po = g_dn[LVL-1].s;
  end else begin : g_sklansky
    // At level l, every bit with bit l of its index set picks up the prefix
    // ending just below its 2^l-aligned group.
    for (genvar l = 0; l < LVL; l++) begin : g_lvl
      logic [WIDTH-1:0] prev, s;
      if (l == 0) begin : g_first
        assign prev = d;
      end else begin : g_next
        assign prev = g_lvl[l-1].s;
      end
      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        if (((i >> l) & 1) == 1) begin : g_op
          assign s[i] = prev[i] & prev[((i >> l) << l) - 1];
        end else begin : g_pass
          assign s[i] = prev[i];
        end
      end
    end
    assign po = g_lvl[LVL-1].s;
  end
endmodule

module au_prefix_and_seq #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8,
  parameter int ARCH  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);
  localparam int NCHUNK = (WIDTH + CHUNK - 1) / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int PADW   = NCHUNK * CHUNK;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state, state_next;
  logic [WIDTH-1:0]  data_q, data_next;
  logic [WIDTH-1:0]  result_q, result_next;
  logic [IDXW-1:0]   idx_q, idx_next;
  logic              carry_q, carry_next;
  logic [PADW-1:0]   padded;
  logic [CHUNK-1:0]  chunk;
  logic [CHUNK-1:0]  po;

  // The last chunk may be partial. Its missing bits read as 1 so they cannot
  // clear the carry, and they are never written back to the result.
  always_comb begin
    padded              = '1;
    padded[WIDTH-1:0]   = data_q;
    chunk               = padded[CHUNK-1:0];
    for (int c = 0; c < NCHUNK; c++) begin
      if (idx_q == IDXW'(c)) chunk = padded[c*CHUNK +: CHUNK];
    end
  end

  au_prefix_and #(.WIDTH(CHUNK), .ARCH(ARCH)) u_prefix (
    .d  (chunk),
    .po (po)
  );

  // Each RUN cycle writes one result slice and moves the carry forward. The
  // block finishes on the last chunk or as soon as the carry is 0.
  always_comb begin
    state_next  = state;
    data_next   = data_q;
    result_next = result_q;
    idx_next    = idx_q;
    carry_next  = carry_q;
    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          data_next   = in_data;
          result_next = '0;
          idx_next    = '0;
          carry_next  = 1'b1;
          state_next  = RUN;
        end
      end
      RUN: begin
        for (int p = 0; p < WIDTH; p++) begin
          if (idx_q == IDXW'(p / CHUNK)) result_next[p] = po[p % CHUNK] & carry_q;
        end
        carry_next = carry_q & po[CHUNK-1];
        idx_next   = idx_q + 1'b1;
        if ((idx_q == IDXW'(NCHUNK - 1)) || !carry_next) state_next = DONE;
      end
      DONE: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register with synchronous reset. A reset drops any word in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      data_q   <= '0;
      result_q <= '0;
      idx_q    <= '0;
      carry_q  <= 1'b1;
    end else begin
      state    <= state_next;
      data_q   <= data_next;
      result_q <= result_next;
      idx_q    <= idx_next;
      carry_q  <= carry_next;
    end
  end

  assign in_ready  = (state == IDLE) & ~rst;
  assign out_valid = (state == DONE);
  assign out_data  = result_q;
  assign busy      = (state != IDLE);
endmodule

// File: tb/tb_au_prefix_and_seq.sv
// -----------------------------------------------------------------------------
// tb_au_prefix_and_seq
//   Runs three WIDTH=16/CHUNK=4 instances (ARCH 0, 1, 2) side by side on a
//   shared input bus. A fourth WIDTH=10/CHUNK=4 instance has its own in_valid.
//   Vectors come from a table of hand-computed results and latencies. Two
//   hand-written sequences cover backpressure and reset abort.
// -----------------------------------------------------------------------------

module tb_au_prefix_and_seq;
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset;
  logic        in_valid;
  logic        in_valid_w10;
  logic        out_ready;
  logic [15:0] in_data;

  logic [2:0]  in_ready16, out_valid16, busy16;
  logic [15:0] out_data16 [0:2];
  logic        in_ready10, out_valid10, busy10;
  logic [9:0]  out_data10;

  int vec_count = 0;
  int err_count = 0;

  for (genvar a = 0; a < 3; a++) begin : g_dut
    au_prefix_and_seq #(.WIDTH(16), .CHUNK(4), .ARCH(a)) u_dut (
      .clk       (clock),
      .rst       (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready16[a]),
      .in_data   (in_data),
      .out_valid (out_valid16[a]),
      .out_ready (out_ready),
      .out_data  (out_data16[a]),
      .busy      (busy16[a])
    );
  end

  au_prefix_and_seq #(.WIDTH(10), .CHUNK(4), .ARCH(2)) u_dut_w10 (
    .clk       (clock),
    .rst       (reset),
    .in_valid  (in_valid_w10),
    .in_ready  (in_ready10),
    .in_data   (in_data[9:0]),
    .out_valid (out_valid10),
    .out_ready (out_ready),
    .out_data  (out_data10),
    .busy      (busy10)
  );

  typedef struct {
    bit          w10;
    logic [15:0] data;
    logic [15:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs [15];

  // Accessors give uniform access to instance d (0..2 = 16-bit ARCH d, 3 = w10).
  function automatic logic [15:0] get_data(int d);
    return (d == 3) ? {6'b0, out_data10} : out_data16[d];
  endfunction
  function automatic logic get_valid(int d);
    return (d == 3) ? out_valid10 : out_valid16[d];
  endfunction
  function automatic logic get_ready(int d);
    return (d == 3) ? in_ready10 : in_ready16[d];
  endfunction
  function automatic logic get_busy(int d);
    return (d == 3) ? busy10 : busy16[d];
  endfunction

  task automatic checkOutput(input string name, input int d,
                             input logic [15:0] act, input logic [15:0] exp);
    vec_count++;
    if (act !== exp) begin
      err_count++;
      $display("[TB] FAIL %s dut%0d: got %h, expected %h at %0t", name, d, act, exp, $time);
    end
  endtask

  // Offers one word at a negedge and checks out_valid at the expected cycle.
  // Cycle 0 is the acceptance cycle. The task then completes the handshake.
  task automatic applyStimulus(input vec_t v);
    int lo, hi;
    lo = v.w10 ? 3 : 0;
    hi = v.w10 ? 3 : 2;
    @(negedge clock);
    for (int d = lo; d <= hi; d++) checkOutput("in_ready_idle", d, 16'(get_ready(d)), 16'h1);
    in_data = v.data;
    if (v.w10) in_valid_w10 = 1'b1;
    else       in_valid     = 1'b1;
    @(posedge clock);
    #1;
    in_valid     = 1'b0;
    in_valid_w10 = 1'b0;
    in_data      = ~v.data;
    for (int cyc = 1; cyc <= v.lat; cyc++) begin
      @(negedge clock);
      if (cyc == v.lat - 1)
        for (int d = lo; d <= hi; d++) checkOutput("valid_early", d, 16'(get_valid(d)), 16'h0);
    end
    for (int d = lo; d <= hi; d++) begin
      checkOutput("valid_latency", d, 16'(get_valid(d)), 16'h1);
      checkOutput("out_data", d, get_data(d), v.exp);
      checkOutput("busy_done", d, 16'(get_busy(d)), 16'h1);
    end
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    out_ready = 1'b0;
    @(negedge clock);
    for (int d = lo; d <= hi; d++) begin
      checkOutput("valid_after_hs", d, 16'(get_valid(d)), 16'h0);
      checkOutput("busy_after_hs", d, 16'(get_busy(d)), 16'h0);
    end
  endtask

  initial begin
    vecs[0]  = '{1'b0, 16'hFFFF, 16'hFFFF, 5};
    vecs[1]  = '{1'b0, 16'hFFEF, 16'h000F, 3};
    vecs[2]  = '{1'b0, 16'h00FF, 16'h00FF, 4};
    vecs[3]  = '{1'b0, 16'h0000, 16'h0000, 2};
    vecs[4]  = '{1'b0, 16'h7FFF, 16'h7FFF, 5};
    vecs[5]  = '{1'b0, 16'hF0FF, 16'h00FF, 4};
    vecs[6]  = '{1'b0, 16'h0001, 16'h0001, 2};
    vecs[7]  = '{1'b0, 16'hFFF7, 16'h0007, 2};
    vecs[8]  = '{1'b0, 16'h1FFF, 16'h1FFF, 5};
    vecs[9]  = '{1'b0, 16'hEFFF, 16'h0FFF, 5};
    vecs[10] = '{1'b1, 16'h03FF, 16'h03FF, 4};
    vecs[11] = '{1'b1, 16'h02FF, 16'h00FF, 4};
    vecs[12] = '{1'b1, 16'h01FF, 16'h01FF, 4};
    vecs[13] = '{1'b1, 16'h037F, 16'h007F, 3};
    vecs[14] = '{1'b1, 16'h0000, 16'h0000, 2};

    reset        = 1'b1;
    in_valid     = 1'b0;
    in_valid_w10 = 1'b0;
    out_ready    = 1'b0;
    in_data      = 16'h0;

    // Reset state
    repeat (3) @(posedge clock);
    @(negedge clock);
    for (int d = 0; d < 4; d++) begin
      checkOutput("rst_in_ready", d, 16'(get_ready(d)), 16'h0);
      checkOutput("rst_out_valid", d, 16'(get_valid(d)), 16'h0);
      checkOutput("rst_busy", d, 16'(get_busy(d)), 16'h0);
      checkOutput("rst_out_data", d, get_data(d), 16'h0);
    end
    reset = 1'b0;
    @(negedge clock);
    for (int d = 0; d < 4; d++) checkOutput("in_ready_after_rst", d, 16'(get_ready(d)), 16'h1);

    for (int i = 0; i < 15; i++) applyStimulus(vecs[i]);

    // Backpressure: result held for 10 cycles while a second word waits
    @(negedge clock);
    in_data  = 16'h00FF;
    in_valid = 1'b1;
    @(posedge clock);
    #1;
    in_data = 16'hFFFF;
    for (int cyc = 1; cyc <= 4; cyc++) @(negedge clock);
    for (int k = 0; k < 10; k++) begin
      if (k > 0) @(negedge clock);
      for (int d = 0; d < 3; d++) begin
        checkOutput("bp_valid", d, 16'(get_valid(d)), 16'h1);
        checkOutput("bp_data", d, get_data(d), 16'h00FF);
        checkOutput("bp_in_ready", d, 16'(get_ready(d)), 16'h0);
      end
    end
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    out_ready = 1'b0;
    @(negedge clock);
    for (int d = 0; d < 3; d++) begin
      checkOutput("bp_second_ready", d, 16'(get_ready(d)), 16'h1);
      checkOutput("bp_valid_dropped", d, 16'(get_valid(d)), 16'h0);
    end
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    for (int cyc = 1; cyc <= 5; cyc++) begin
      @(negedge clock);
      if (cyc == 4)
        for (int d = 0; d < 3; d++) checkOutput("bp2_valid_early", d, 16'(get_valid(d)), 16'h0);
    end
    for (int d = 0; d < 3; d++) begin
      checkOutput("bp2_valid", d, 16'(get_valid(d)), 16'h1);
      checkOutput("bp2_data", d, get_data(d), 16'hFFFF);
    end
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    out_ready = 1'b0;

    // Reset during RUN aborts the word
    @(negedge clock);
    in_data  = 16'hFFFF;
    in_valid = 1'b1;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    @(negedge clock);
    for (int d = 0; d < 3; d++) checkOutput("abort_busy_run", d, 16'(get_busy(d)), 16'h1);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    for (int d = 0; d < 3; d++) begin
      checkOutput("abort_valid", d, 16'(get_valid(d)), 16'h0);
      checkOutput("abort_data", d, get_data(d), 16'h0);
      checkOutput("abort_busy", d, 16'(get_busy(d)), 16'h0);
      checkOutput("abort_in_ready", d, 16'(get_ready(d)), 16'h1);
    end
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      for (int d = 0; d < 3; d++) checkOutput("abort_no_result", d, 16'(get_valid(d)), 16'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end
endmodule
